// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: issues word fetches to a variable-latency instruction memory and
// buffers {pc, word} pairs in a small FIFO presented to decode through a valid/ready handshake.
module instr_prefetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_W    = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [PTR_W:0] DepthCnt = (PTR_W + 1)'(DEPTH);

  logic [1:0]       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      addr_q, addr_d;
  logic [PTR_W:0]   count_q, count_d, count_next;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] mem_instr_q [DEPTH];
  logic [31:0] mem_pc_q    [DEPTH];

  logic push;
  logic pop;
  logic space;

  assign instr_valid = (count_q != '0);
  assign instr       = mem_instr_q[rd_ptr_q];
  assign instr_pc    = mem_pc_q[rd_ptr_q];
  assign imem_req    = (state_q != StIdle);
  assign imem_addr   = addr_q;

  // Redirect kills both the returning word and any consumer pop in the same cycle.
  assign push = (state_q == StFetch) && imem_ack && !redirect;
  assign pop  = instr_valid && instr_ready && !redirect;

  // A same-cycle pop frees a slot for the space check.
  assign count_next = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
  assign space      = (count_next < DepthCnt);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc & ~32'h0000_0003;
    end

    unique case (state_q)
      StIdle: begin
        if (!redirect && space) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (redirect) begin
          state_d = imem_ack ? StIdle : StDrain;
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = space ? StFetch : StIdle;
        end
      end
      StDrain: begin
        // The outstanding handshake must complete; its word is discarded.
        if (imem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new request always targets the updated fetch address; a draining one keeps its address.
    if (state_d == StFetch) begin
      addr_d = fetch_pc_d;
    end
  end

  always_comb begin
    count_d  = count_next;
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only observed while count is nonzero.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_instr_q[wr_ptr_q] <= imem_rdata;
      mem_pc_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

endmodule
